// File: rtl/enc_event_uart.sv
// enc_event_uart: queue encoder-bus event codes in a FIFO and send each as one 8N1 UART byte
module enc_event_uart #(
  parameter int DEPTH = 8,
  parameter int CLK_DIV = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               evt_flag,
  input  logic [5:0]               evt_code,
  input  logic                     clr_ovf,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     fifo_full,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic [15:0] baud;
  logic push, pop, accept, tick;
  always_comb begin
    push = 1'b0;
    if (evt_flag == 2'b11) push = 1'b1;
    pop = (state == IDLE) && (fifo_cnt != '0);
    accept = push && (!fifo_full || pop);
    tick = baud == LAST;
  end
  assign busy = state != IDLE;
  assign fifo_full = fifo_cnt == CW'(DEPTH);
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= {2'b01, evt_code};
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
      shift <= '0;
      bit_cnt <= '0;
      baud <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(accept) - CW'(pop);
      overflow <= (push && !accept) || (overflow && !clr_ovf);
      baud <= (state == IDLE || tick) ? '0 : baud + 16'd1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            bit_cnt <= '0;
            tx <= 1'b0;
            state <= START;
          end
        end
        START: if (tick) begin
          tx <= shift[0];
          state <= DATA;
        end
        DATA: if (tick) begin
          shift <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          tx <= (bit_cnt == 3'd7) ? 1'b1 : shift[1];
          state <= (bit_cnt == 3'd7) ? STOP : DATA;
        end
        STOP: if (tick) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_enc_event_uart.sv
// tb_enc_event_uart: randomized self-checking bench for enc_event_uart against a queue-based model
module tb_enc_event_uart;
  localparam int DEPTH = 8;
  localparam int D = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] evt_flag = 2'b00;
  logic [5:0] evt_code = '0;
  logic clr_ovf = 1'b0;
  logic tx, busy, fifo_full, overflow;
  logic [CW-1:0] fifo_cnt;
  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int busy_left = 0;
  bit m_ovf = 1'b0;
  bit armed = 1'b0;
  enc_event_uart #(.DEPTH(DEPTH), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .evt_flag(evt_flag), .evt_code(evt_code), .clr_ovf(clr_ovf),
    .tx(tx), .busy(busy), .fifo_cnt(fifo_cnt), .fifo_full(fifo_full), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic model();
    bit p, pn, acc;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        exp_q.delete();
        busy_left = 0;
        m_ovf = 1'b0;
      end else begin
        p = (evt_flag === 2'b11);
        pn = (busy_left == 0) && (mq.size() > 0);
        acc = p && ((mq.size() < DEPTH) || pn);
        if (pn) begin
          exp_q.push_back(mq.pop_front());
          busy_left = 10 * D;
        end else if (busy_left > 0) busy_left--;
        if (acc) mq.push_back({2'b01, evt_code});
        if (p && !acc) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
      end
    end
  endtask
  task automatic rx_mon();
    bit in_frame, tail, busy_ok;
    int cyc, j;
    logic [7:0] byte_v, e;
    in_frame = 0;
    tail = 0;
    busy_ok = 1;
    cyc = 0;
    byte_v = '0;
    forever begin
      @(negedge clk);
      if (armed) begin
        checks++;
        if (fifo_cnt !== CW'(mq.size())) begin
          errors++;
          $display("FAIL fifo_cnt: got %0d expected %0d at %0t", fifo_cnt, mq.size(), $time);
        end
        checks++;
        if (fifo_full !== (mq.size() == DEPTH)) begin
          errors++;
          $display("FAIL fifo_full: got %b expected %b at %0t", fifo_full, mq.size() == DEPTH, $time);
        end
        checks++;
        if (overflow !== m_ovf) begin
          errors++;
          $display("FAIL overflow: got %b expected %b at %0t", overflow, m_ovf, $time);
        end
      end
      if (rst) begin
        in_frame = 0;
        tail = 0;
      end else if (armed) begin
        if (tail) begin
          tail = 0;
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_end_busy: got %b expected 0 at %0t", busy, $time);
          end
        end
        if (in_frame) begin
          if (busy !== 1'b1) busy_ok = 0;
          if (cyc % D == D / 2) begin
            j = cyc / D;
            if (j == 0) begin
              checks++;
              if (tx !== 1'b0) begin
                errors++;
                $display("FAIL start_bit: got %b expected 0 at %0t", tx, $time);
              end
            end else if (j == 9) begin
              checks++;
              if (tx !== 1'b1) begin
                errors++;
                $display("FAIL stop_bit: got %b expected 1 at %0t", tx, $time);
              end
            end else byte_v[j-1] = tx;
          end
          if (cyc == 10 * D - 1) begin
            in_frame = 0;
            tail = 1;
            checks++;
            if (!busy_ok) begin
              errors++;
              $display("FAIL busy_in_frame: got 0 expected 1 during frame ending %0t", $time);
            end
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rx_byte: got %h expected no frame at %0t", byte_v, $time);
            end else begin
              e = exp_q.pop_front();
              if (byte_v !== e) begin
                errors++;
                $display("FAIL rx_byte: got %h expected %h at %0t", byte_v, e, $time);
              end
            end
            rx_log.push_back(byte_v);
          end
          cyc++;
        end else if (tx === 1'b0) begin
          in_frame = 1;
          cyc = 1;
          busy_ok = (busy === 1'b1);
        end
      end
    end
  endtask
  task automatic tick(input logic [1:0] f, input logic [5:0] c, input logic clr);
    evt_flag = f;
    evt_code = c;
    clr_ovf = clr;
    @(posedge clk);
    #1;
    evt_flag = 2'b00;
    clr_ovf = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) tick(2'b00, 6'h00, 1'b0);
  endtask
  task automatic wait_drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || busy_left != 0 || exp_q.size() != 0) && n < 5000) begin
      tick(2'b00, 6'h00, 1'b0);
      n++;
    end
    idle(3);
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d queued expected 0", mq.size());
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    evt_flag = 2'bzz;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    armed = 1'b1;
    repeat (100) begin
      @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL reset_tx: got %b expected 1", tx);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (fifo_cnt !== '0) begin
        errors++;
        $display("FAIL reset_cnt: got %0d expected 0", fifo_cnt);
      end
      checks++;
      if (overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_ovf: got %b expected 0", overflow);
      end
    end
    evt_flag = 2'b00;
  endtask
  task automatic test_single();
    int base, n;
    base = rx_log.size();
    tick(2'b11, 6'h05, 1'b0);
    checks++;
    if (fifo_cnt !== CW'(1) || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_push: got cnt %0d tx %b expected cnt 1 tx 1", fifo_cnt, tx);
    end
    tick(2'b00, 6'h00, 1'b0);
    checks++;
    if (fifo_cnt !== CW'(0) || tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_pop: got cnt %0d tx %b busy %b expected 0 0 1", fifo_cnt, tx, busy);
    end
    n = 1;
    while (busy === 1'b1 && n < 1000) begin
      tick(2'b00, 6'h00, 1'b0);
      if (busy === 1'b1) n++;
    end
    checks++;
    if (n != 10 * D) begin
      errors++;
      $display("FAIL frame_len: got %0d expected %0d", n, 10 * D);
    end
    wait_drain();
    checks++;
    if (rx_log.size() != base + 1 || rx_log[rx_log.size()-1] !== 8'h45) begin
      errors++;
      $display("FAIL single_byte: got %0d frames last %h expected 1 frame 45", rx_log.size() - base, rx_log[rx_log.size()-1]);
    end
  endtask
  task automatic test_burst();
    int base, peak;
    base = rx_log.size();
    peak = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(2'b11, 6'(i), 1'b0);
      if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
    end
    checks++;
    if (peak != 7) begin
      errors++;
      $display("FAIL burst_peak: got %0d expected 7", peak);
    end
    wait_drain();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL burst_ovf: got %b expected 0", overflow);
    end
    checks++;
    if (rx_log.size() != base + 8) begin
      errors++;
      $display("FAIL burst_count: got %0d expected 8", rx_log.size() - base);
    end else
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rx_log[base+i] !== 8'(8'h41 + i)) begin
          errors++;
          $display("FAIL burst_order: got %h expected %h", rx_log[base+i], 8'(8'h41 + i));
        end
      end
  endtask
  task automatic test_overflow();
    int base;
    logic [5:0] codes[10];
    base = rx_log.size();
    for (int i = 0; i < 10; i++) begin
      codes[i] = 6'($urandom);
      tick(2'b11, codes[i], 1'b0);
    end
    checks++;
    if (overflow !== 1'b1 || fifo_cnt !== CW'(DEPTH) || fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got ovf %b cnt %0d full %b expected 1 %0d 1", overflow, fifo_cnt, fifo_full, DEPTH);
    end
    tick(2'b00, 6'h00, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    tick(2'b11, 6'($urandom), 1'b1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b expected 1", overflow);
    end
    wait_drain();
    checks++;
    if (rx_log.size() != base + 9) begin
      errors++;
      $display("FAIL ovf_count: got %0d expected 9", rx_log.size() - base);
    end else
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (rx_log[base+i] !== {2'b01, codes[i]}) begin
          errors++;
          $display("FAIL ovf_order: got %h expected %h", rx_log[base+i], {2'b01, codes[i]});
        end
      end
    tick(2'b00, 6'h00, 1'b1);
  endtask
  task automatic test_full_pushpop();
    int base, n;
    logic [5:0] codes[10];
    base = rx_log.size();
    for (int i = 0; i < 9; i++) begin
      codes[i] = 6'($urandom);
      tick(2'b11, codes[i], 1'b0);
    end
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got %b expected 1", fifo_full);
    end
    n = 0;
    while (busy_left != 0 && n < 1000) begin
      tick(2'b00, 6'h00, 1'b0);
      n++;
    end
    codes[9] = 6'($urandom);
    tick(2'b11, codes[9], 1'b0);
    checks++;
    if (fifo_cnt !== CW'(DEPTH) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: got cnt %0d ovf %b expected %0d 0", fifo_cnt, overflow, DEPTH);
    end
    wait_drain();
    checks++;
    if (rx_log.size() != base + 10) begin
      errors++;
      $display("FAIL wrap_count: got %0d expected 10", rx_log.size() - base);
    end else
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (rx_log[base+i] !== {2'b01, codes[i]}) begin
          errors++;
          $display("FAIL wrap_order: got %h expected %h", rx_log[base+i], {2'b01, codes[i]});
        end
      end
  endtask
  task automatic test_reset_midframe();
    int base;
    logic [5:0] c;
    repeat (3) tick(2'b11, 6'($urandom), 1'b0);
    idle(16);
    checks++;
    if (fifo_cnt !== CW'(2) || busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_setup: got cnt %0d busy %b expected 2 1", fifo_cnt, busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || fifo_cnt !== CW'(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got tx %b cnt %0d busy %b expected 1 0 0", tx, fifo_cnt, busy);
    end
    idle(5);
    base = rx_log.size();
    c = 6'($urandom);
    tick(2'b11, c, 1'b0);
    wait_drain();
    checks++;
    if (rx_log.size() != base + 1 || rx_log[rx_log.size()-1] !== {2'b01, c}) begin
      errors++;
      $display("FAIL post_reset_frame: got %0d frames last %h expected 1 frame %h", rx_log.size() - base, rx_log[rx_log.size()-1], {2'b01, c});
    end
  endtask
  task automatic test_random();
    logic [1:0] f;
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      tick(f, 6'($urandom), $urandom_range(0, 15) == 0);
    end
    wait_drain();
  endtask
  initial begin
    fork
      model();
      rx_mon();
    join_none
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_pushpop();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/enc_event_uart.md
# enc_event_uart

Downstream consumer of the encoder-reader stage. Samples the shared encoder event bus (2-bit event flag plus 6-bit event code, driven by up to 32 encoder readers), queues each event code in a small FIFO and transmits it to the host controller as one 8N1 UART byte per event. Provides overflow and status flags to the keyboard top level.

## Interface

Parameters:
- DEPTH, 8: FIFO depth in entries; power of two, 2..64.
- CLK_DIV, 16: clk cycles per UART bit; 2..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- evt_flag  in  2  shared event bus flag; 2'b11 = event this cycle; any other value, including undriven/x/z, = no event.
- evt_code  in  6  event code; valid only when evt_flag == 2'b11.
- clr_ovf  in  1  single-cycle clear of the overflow flag.
- tx  out  1  UART line, idle high; registered.
- busy  out  1  high while a frame is on the line (START..STOP).
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.
- fifo_full  out  1  fifo_cnt == DEPTH.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

## Operation

- Capture: on each rising edge where evt_flag == 2'b11 (exact compare; x/z never matches), the word {2'b01, evt_code} is pushed. Back-to-back event cycles are each separate events.
- FIFO: circular buffer, write/read pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy counter of $clog2(DEPTH)+1 bits.
  - Push with count < DEPTH: store, write pointer +1.
  - Push when full with no pop in the same cycle: word dropped, overflow <= 1, pointers and count unchanged.
  - Push and pop in the same cycle: both occur; count unchanged, including when full (no overflow) and when count == 1.
  - Pop when empty never happens (FSM only pops when count != 0).
- overflow: set by a dropped push, cleared by clr_ovf; if both in the same cycle, set wins.
- Transmitter FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx = 1. If count != 0: pop head into shift register, bit counter = 0, baud counter = 0, go START.
  - START: tx = 0 for CLK_DIV cycles, then DATA.
  - DATA: tx = shift[0], LSB first, each bit held CLK_DIV cycles; shift right after each bit; after bit 7 go STOP.
  - STOP: tx = 1 for CLK_DIV cycles, then IDLE.
- busy = 1 in START, DATA, STOP.
- Baud counter: 16 bits, counts 0..CLK_DIV-1, reset to 0 on each bit boundary.

## Timing

- Reset values: tx = 1, busy = 0, fifo_cnt = 0, fifo_full = 0, overflow = 0, FSM = IDLE, pointers = 0. Applies on the edge where rst = 1 regardless of state; an in-progress frame is truncated (tx high from the next cycle), and queued entries are discarded.
- Event on edge N with empty FIFO and FSM in IDLE: fifo_cnt = 1 after edge N; pop on edge N+1 (fifo_cnt back to 0); tx falls after edge N+1, so start bit occupies cycles N+2..N+1+CLK_DIV.
- Frame length exactly 10*CLK_DIV cycles from tx falling to the IDLE decision. A non-empty FIFO in IDLE pops on the first IDLE edge, so back-to-back frames have a gap of 1 cycle of tx = 1 beyond the stop bit.
- fifo_full and fifo_cnt reflect the registered state (updated the cycle after push/pop).
- Inputs evt_flag/evt_code are assumed synchronous to clk (upstream is same-clock); no synchronizer.

## Test plan

- Reset/idle: hold rst 3 cycles, release -> tx = 1, busy = 0, fifo_cnt = 0, overflow = 0 for 100 cycles with evt_flag = 2'bzz.
- Single event: CLK_DIV = 4, evt_flag = 2'b11, evt_code = 6'h05 for one cycle -> tx low 2 cycles later, serial byte 8'h45 LSB first (1,0,1,0,0,0,1,0), stop high, frame 40 cycles, busy high throughout.
- Burst and ordering: codes 6'h01..6'h08 on 8 consecutive cycles, DEPTH = 8 -> fifo_cnt peaks at 7 (one popped immediately), bytes 8'h41..8'h48 in order, overflow stays 0.
- Overflow: 10 consecutive events while one frame is in flight, DEPTH = 8 -> first popped, next 8 stored, 10th dropped, overflow = 1, 9 bytes transmitted; clr_ovf pulse -> overflow = 0; clr_ovf coincident with a drop -> overflow stays 1.
- Full with simultaneous push/pop: FIFO full, event arrives on the pop edge -> accepted, fifo_cnt stays DEPTH, overflow = 0, pointers wrap correctly (verify byte order across wrap).
- Reset mid-frame: assert rst during DATA bit 3 with 2 entries queued -> tx = 1 next cycle, fifo_cnt = 0, busy = 0; new event after release transmits a clean full frame.
